// File: rtl/toggle_cover_collector.sv
// ============================================================================
// toggle_cover_collector: sticky first-hit detector serialising cover indices
// Rev 1.0
// ============================================================================
`default_nettype none

module toggle_cover_collector #(
    parameter int WIDTH       = 37,
    parameter int COVER_INDEX = 0,
    parameter int INDEX_W     = 32,
    parameter int COUNT_W     = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [WIDTH-1:0]   valid,
    input  logic               clear,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INDEX_W-1:0] out_index,
    output logic [COUNT_W-1:0] covered_count,
    output logic               all_covered
);

    localparam int    c_BIT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int    c_CNT_W     = $clog2(WIDTH + 1);
    localparam longint c_MAX_INDEX = longint'(COVER_INDEX) + longint'(WIDTH) - 1;

    generate
        if ((c_MAX_INDEX >> INDEX_W) != 0) begin : g_index_overflow
            $error("toggle_cover_collector: COVER_INDEX + WIDTH - 1 does not fit in INDEX_W");
        end
        if (longint'(WIDTH) >= (longint'(1) << COUNT_W)) begin : g_count_overflow
            $error("toggle_cover_collector: WIDTH must be below 2**COUNT_W");
        end
    endgenerate

    logic [WIDTH-1:0]   r_covered;
    logic [WIDTH-1:0]   r_pending;
    logic               r_out_valid;
    logic [INDEX_W-1:0] r_out_index;
    logic [COUNT_W-1:0] r_count;
    logic               r_all_covered;

    logic [WIDTH-1:0]   w_new;
    logic [WIDTH-1:0]   w_covered_next;
    logic [WIDTH-1:0]   w_sel_mask;
    logic [WIDTH-1:0]   w_pend_left;
    logic [c_BIT_W-1:0] w_sel_idx;
    logic [c_CNT_W-1:0] w_new_cnt;
    logic [COUNT_W:0]   w_sum;
    logic [COUNT_W-1:0] w_count_next;
    logic               w_load;
    logic               w_any_pending;

    always_comb begin
        w_new          = valid & ~r_covered;
        w_covered_next = r_covered | valid;
        w_load         = !r_out_valid || out_ready;
        w_any_pending  = |r_pending;
        // Two's-complement trick isolates the lowest pending bit.
        w_sel_mask     = r_pending & (~r_pending + WIDTH'(1));
        w_pend_left    = w_load ? (r_pending & ~w_sel_mask) : r_pending;

        w_sel_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_sel_idx = c_BIT_W'(i);
            end
        end

        w_new_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_new_cnt = w_new_cnt + c_CNT_W'(w_new[i]);
        end

        w_sum        = {1'b0, r_count} + (COUNT_W + 1)'(w_new_cnt);
        w_count_next = w_sum[COUNT_W] ? {COUNT_W{1'b1}} : w_sum[COUNT_W-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_covered     <= '0;
            r_pending     <= '0;
            r_out_valid   <= 1'b0;
            r_out_index   <= '0;
            r_count       <= '0;
            r_all_covered <= 1'b0;
        end else if (clear) begin
            r_covered     <= '0;
            r_pending     <= '0;
            r_count       <= '0;
            r_all_covered <= 1'b0;
            // A stalled beat survives clear; only its acceptance frees the slot.
            if (w_load) begin
                r_out_valid <= 1'b0;
            end
        end else begin
            r_covered     <= w_covered_next;
            r_pending     <= w_pend_left | w_new;
            r_count       <= w_count_next;
            r_all_covered <= &w_covered_next;
            if (w_load) begin
                r_out_valid <= w_any_pending;
                if (w_any_pending) begin
                    r_out_index <= INDEX_W'(COVER_INDEX) + INDEX_W'(w_sel_idx);
                end
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign out_index     = r_out_index;
    assign covered_count = r_count;
    assign all_covered   = r_all_covered;

endmodule

`default_nettype wire

// File: doc/toggle_cover_collector.md
Name: toggle_cover_collector

Overview:
- Synthesizable receiving end of the toggle-coverage event stream: consumes the per-cycle `valid` hit vector that each toggle-coverage point group produces.
- Keeps a sticky hit bitmap and detects first-time hits.
- Serializes each newly covered point as a global cover index on a valid/ready stream.
- Sits beside each coverage point group in FPGA/formal builds where the simulator DPI sink is unavailable. Feeds the coverage uplink arbiter.

Parameters:
- WIDTH, 37, number of coverage points in this group (bits of `valid`).
- COVER_INDEX, 0, global index of bit 0; out_index = COVER_INDEX + bit position.
- INDEX_W, 32, width of out_index.
- COUNT_W, 16, width of covered_count.

Ports:
- clock  input  1  single clock.
- reset  input  1  synchronous, active-high reset.
- valid  input  WIDTH  per-point hit strobes, sampled every clock.
- clear  input  1  synchronous pulse; restarts coverage collection.
- out_valid  output  1  a first-hit index is presented.
- out_ready  input  1  downstream accepts the beat.
- out_index  output  INDEX_W  global cover index of the first-hit point.
- covered_count  output  COUNT_W  number of distinct points hit since reset/clear.
- all_covered  output  1  every point in the group has been hit.

Behaviour:
- Reset, synchronous, active-high. Sets covered bitmap=0, pending=0, out_valid=0, out_index=0, covered_count=0, all_covered=0. Reset overrides clear, valid and handshake in the same cycle.
- Each non-reset edge without clear:
  - new = valid & ~covered
  - covered |= valid
  - pending |= new
  - covered_count += popcount(new), saturating at 2^COUNT_W-1
- all_covered: registered, equals &covered after the update. It rises on the same edge the last point's covered bit sets.
- Output stage is a single register, with load = !out_valid || out_ready.
  - On load, if pending (registered value, before this cycle's new bits) is nonzero:
    - select the lowest set bit b;
    - out_index <= COVER_INDEX + b (zero-extended to INDEX_W);
    - out_valid <= 1;
    - clear pending[b].
  - On load with pending==0: out_valid <= 0; out_index holds its last value.
- Latency: a first hit sampled at edge E sets pending at E. The beat is loaded at E+1 and is visible in the cycle after E+1 when the output is free. Minimum latency is 2 edges.
- Throughput: with out_ready held high, one beat per cycle.
- Backpressure: while out_valid && !out_ready, out_index and out_valid hold stable. The pending bitmap keeps accumulating.
- No loss: every point is reported exactly once per reset/clear epoch. Pending cannot overflow, since each point holds at most one pending bit.
- Repeated hits of an already covered point produce no beat and no count change.
- Simultaneous first hits of several points are all reported, in ascending bit order.
- Clear:
  - zeroes covered, pending, covered_count and all_covered;
  - valid bits in the clear cycle are ignored;
  - a beat already in the output register (out_valid=1) stays until accepted; no new beats load during the clear cycle.
- Points hit after clear are reported again as new first hits.
- COVER_INDEX + WIDTH - 1 must fit in INDEX_W. WIDTH must be < 2^COUNT_W. Both are checked by elaboration-time assertion.

Test Plan:
1. Single hit: after reset, valid=1<<5 for one cycle, out_ready=1 -> exactly one beat, out_index=5, 2 edges after sampling. covered_count=1. all_covered=0.
2. Full burst: valid = all 37 ones for one cycle, out_ready=1 -> 37 consecutive beats with out_index 0..36 in order. covered_count=37 and all_covered=1 one edge after sampling. Then out_valid=0.
3. Backpressure: hits on bits 3 and 7, out_ready=0 for 5 cycles -> out_valid=1 with out_index=3 held stable. Raise out_ready -> beats 3 then 7, no duplicates.
4. Repeat and overlap: hit bit 5, then valid=(1<<5)|(1<<9) -> only one further beat, index 9. covered_count goes 1 then 2.
5. Clear with simultaneous valid: with a beat stalled (index 2), pulse clear with valid=1<<4 -> index 2 is still delivered; bit 4 is not reported. covered_count=0. A later hit on bit 2 is reported again.
6. Reset mid-drain: after a 37-bit burst, assert reset after 10 beats -> out_valid=0, out_index=0, covered_count=0 the next cycle. No further beats until new hits arrive.
